// File: rtl/draw_rot_sprite.sv
// Rotating-sprite raster engine: on plot, walks a SPRITE_SIZE x SPRITE_SIZE frame
// of a packed multi-direction ROM and emits clipped, colour-keyed framebuffer writes.
// Latency: first ROM address one cycle after plot; its pixel appears ROM_LAT cycles
// later; draw_done pulses in cycle S*S+ROM_LAT+1. No backpressure: the framebuffer
// must accept one write per cycle.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   plot, x_pos, y_pos, direction  start request and sprite placement (sampled in IDLE)
//   rom_address / rom_data       packed ROM read port {direction,row,col}
//   x, y, color, writeEn         framebuffer write port
//   busy, draw_done, state       status
module draw_rot_sprite #(
  parameter int SPRITE_SIZE = 32,
  parameter int DIR_BITS    = 4,
  parameter int COLOR_W     = 3,
  parameter int TRANSP      = 0,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int ROM_LAT     = 1,
  localparam int ADDR_W     = DIR_BITS + 2 * $clog2(SPRITE_SIZE)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                plot,
  input  logic [9:0]          x_pos,
  input  logic [9:0]          y_pos,
  input  logic [DIR_BITS-1:0] direction,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [COLOR_W-1:0]  rom_data,
  output logic [9:0]          x,
  output logic [9:0]          y,
  output logic [COLOR_W-1:0]  color,
  output logic                writeEn,
  output logic                busy,
  output logic                draw_done,
  output logic [1:0]          state
);

  localparam int CW = $clog2(SPRITE_SIZE);
  localparam logic [CW-1:0]      LAST       = CW'(SPRITE_SIZE - 1);
  localparam logic [1:0]         FLUSH_LAST = 2'(ROM_LAT - 1);
  localparam logic [10:0]        X_LIM      = 11'(SCREEN_W);
  localparam logic [10:0]        Y_LIM      = 11'(SCREEN_H);
  localparam logic [COLOR_W-1:0] TRANSP_C   = COLOR_W'(TRANSP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [9:0]          bx_q, bx_d;
  logic [9:0]          by_q, by_d;
  logic [DIR_BITS-1:0] bd_q, bd_d;
  logic [CW-1:0]       col_q, col_d;
  logic [CW-1:0]       row_q, row_d;
  logic [1:0]          fcnt_q, fcnt_d;

  // Sequencer
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bd_d    = bd_q;
    col_d   = col_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (plot) begin
          bx_d    = x_pos;
          by_d    = y_pos;
          bd_d    = direction;
          col_d   = '0;
          row_d   = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        // Power-of-two edge: col and row wrap to 0 on their own.
        col_d = col_q + 1'b1;
        if (col_q == LAST) begin
          row_d = row_q + 1'b1;
          if (row_q == LAST) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
          end
        end
      end
      S_FLUSH: begin
        if (fcnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      bd_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bd_q    <= bd_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign rom_address = {bd_q, row_q, col_q};
  assign busy        = (state_q != S_IDLE);
  assign draw_done   = (state_q == S_DONE);
  assign state       = state_q;

  // Delay line matching the ROM read latency, so the last stage lines up with rom_data.
  logic          vld_pipe_q [ROM_LAT];
  logic [CW-1:0] col_pipe_q [ROM_LAT];
  logic [CW-1:0] row_pipe_q [ROM_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        vld_pipe_q[i] <= 1'b0;
        col_pipe_q[i] <= '0;
        row_pipe_q[i] <= '0;
      end
    end else begin
      vld_pipe_q[0] <= (state_q == S_DRAW);
      col_pipe_q[0] <= col_q;
      row_pipe_q[0] <= row_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        col_pipe_q[i] <= col_pipe_q[i-1];
        row_pipe_q[i] <= row_pipe_q[i-1];
      end
    end
  end

  // 11-bit screen coordinates so a sprite overhanging the right/bottom edge is
  // clipped rather than wrapped back to column/row 0.
  logic [10:0] px, py;
  assign px = {1'b0, bx_q} + 11'(col_pipe_q[ROM_LAT-1]);
  assign py = {1'b0, by_q} + 11'(row_pipe_q[ROM_LAT-1]);

  assign writeEn = vld_pipe_q[ROM_LAT-1] & (rom_data != TRANSP_C) & (px < X_LIM) & (py < Y_LIM);

  // x/y/color show the live pixel while writing and hold the last written pixel otherwise.
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    if (writeEn) begin
      x_d     = px[9:0];
      y_d     = py[9:0];
      color_d = rom_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign x     = x_d;
  assign y     = y_d;
  assign color = color_d;

endmodule

// File: tb/tb_draw_rot_sprite.sv
module tb_draw_rot_sprite;

  localparam int S  = 4;
  localparam int SS = S * S;

  logic       clk;
  logic       reset_n;
  logic       plot;
  logic [9:0] x_pos, y_pos;
  logic [3:0] direction;

  logic [7:0] rom_address_a, rom_address_b;
  logic [2:0] rom_data_a, rom_data_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [2:0] color_a, color_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b;
  logic [1:0] state_a, state_b;

  draw_rot_sprite #(.SPRITE_SIZE(S), .DIR_BITS(4), .COLOR_W(3), .TRANSP(0),
                    .SCREEN_W(640), .SCREEN_H(480), .ROM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .plot(plot), .x_pos(x_pos), .y_pos(y_pos),
    .direction(direction), .rom_address(rom_address_a), .rom_data(rom_data_a),
    .x(x_a), .y(y_a), .color(color_a), .writeEn(we_a), .busy(busy_a),
    .draw_done(done_a), .state(state_a));

  draw_rot_sprite #(.SPRITE_SIZE(S), .DIR_BITS(4), .COLOR_W(3), .TRANSP(0),
                    .SCREEN_W(640), .SCREEN_H(480), .ROM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .plot(plot), .x_pos(x_pos), .y_pos(y_pos),
    .direction(direction), .rom_address(rom_address_b), .rom_data(rom_data_b),
    .x(x_b), .y(y_b), .color(color_b), .writeEn(we_b), .busy(busy_b),
    .draw_done(done_b), .state(state_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed sprite ROM shared by both engines, each seen through its own read latency.
  logic [2:0] mem [256];
  logic [7:0] addr_a_q;
  logic [7:0] addr_b_q [3];
  always @(posedge clk) begin
    addr_a_q    <= rom_address_a;
    addr_b_q[0] <= rom_address_b;
    addr_b_q[1] <= addr_b_q[0];
    addr_b_q[2] <= addr_b_q[1];
  end
  assign rom_data_a = mem[addr_a_q];
  assign rom_data_b = mem[addr_b_q[2]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: expected visible pixels of one sprite, in raster order.
  bit vis [SS];
  int ex [SS], ey [SS], ec [SS];
  int exp_total;

  task automatic build_model(input int bx, input int by, input int bd);
    exp_total = 0;
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        int p;
        p = r * S + c;
        ex[p] = bx + c;
        ey[p] = by + r;
        ec[p] = int'(mem[bd * SS + p]);
        vis[p] = (ec[p] != 0) && (ex[p] < 640) && (ey[p] < 480);
        if (vis[p]) exp_total++;
      end
    end
  endtask

  task automatic fill_rom(input int mode);
    for (int a = 0; a < 256; a++) begin
      int frame, c;
      frame = a / SS;
      c = a % S;
      case (mode)
        0: mem[a] = 3'd5;
        1: mem[a] = (c % 2 == 0) ? 3'd0 : 3'd6;
        2: mem[a] = 3'd0;
        3: mem[a] = 3'($urandom_range(0, 7));
        default: mem[a] = 3'(frame % 7 + 1);
      endcase
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " A addr"},  rom_address_a, 0);
    chk({tag, " A we"},    we_a, 0);
    chk({tag, " A x"},     x_a, 0);
    chk({tag, " A y"},     y_a, 0);
    chk({tag, " A color"}, color_a, 0);
    chk({tag, " A busy"},  busy_a, 0);
    chk({tag, " A done"},  done_a, 0);
    chk({tag, " A state"}, state_a, 0);
    chk({tag, " B addr"},  rom_address_b, 0);
    chk({tag, " B we"},    we_b, 0);
    chk({tag, " B x"},     x_b, 0);
    chk({tag, " B busy"},  busy_b, 0);
    chk({tag, " B done"},  done_b, 0);
    chk({tag, " B state"}, state_b, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    plot    = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
  endtask

  // One cycle of checks on one engine; cyc counts cycles after the plot-sampling edge.
  task automatic check_dut(input string tag, input int lat, input int cyc, input int bd,
                           input bit hold, input logic [7:0] addr, input logic we,
                           input logic [9:0] xo, input logic [9:0] yo, input logic [2:0] co,
                           input logic dd, input logic bsy, input logic [1:0] st,
                           inout int wcnt, inout int lx, inout int ly, inout int lc);
    int p;
    bit exp_we;
    string nm;
    p = cyc - 1 - lat;
    exp_we = (p >= 0 && p < SS) ? vis[p] : 1'b0;
    nm = $sformatf("%s c%0d", tag, cyc);
    if (cyc <= SS + lat + 2) begin
      chk({nm, " we"}, we, exp_we);
      if (we) wcnt++;
      if (exp_we) begin
        lx = ex[p]; ly = ey[p]; lc = ec[p];
      end
      chk({nm, " x"}, xo, lx);
      chk({nm, " y"}, yo, ly);
      chk({nm, " color"}, co, lc);
      chk({nm, " done"}, dd, (cyc == SS + lat + 1));
      chk({nm, " busy"}, bsy, (cyc <= SS + lat + 1));
    end
    if (cyc <= SS) begin
      chk({nm, " addr"}, addr, bd * SS + cyc - 1);
      chk({nm, " state"}, st, 1);
    end
    if (hold && cyc == SS + lat + 3) begin
      chk({nm, " restart state"}, st, 1);
      chk({nm, " restart dir"}, addr[7:4], direction);
    end
  endtask

  task automatic run_draw(input int bx, input int by, input int bd, input bit hold,
                          input bit do_rst, output int wa, output int wb);
    int lxa, lya, lca, lxb, lyb, lcb;
    if (do_rst) apply_reset();
    build_model(bx, by, bd);
    wa = 0; wb = 0;
    lxa = 0; lya = 0; lca = 0; lxb = 0; lyb = 0; lcb = 0;
    @(negedge clk);
    plot      = 1'b1;
    x_pos     = 10'(bx);
    y_pos     = 10'(by);
    direction = 4'(bd);
    @(posedge clk);
    for (int cyc = 1; cyc <= SS + 6; cyc++) begin
      @(negedge clk);
      check_dut("A", 1, cyc, bd, hold, rom_address_a, we_a, x_a, y_a, color_a,
                done_a, busy_a, state_a, wa, lxa, lya, lca);
      check_dut("B", 3, cyc, bd, hold, rom_address_b, we_b, x_b, y_b, color_b,
                done_b, busy_b, state_b, wb, lxb, lyb, lcb);
      if (cyc == 1 && !hold) plot = 1'b0;
      if (cyc == 3) begin
        // Mid-draw changes must be ignored.
        x_pos     = 10'($urandom);
        y_pos     = 10'($urandom);
        direction = 4'(bd) ^ 4'($urandom_range(1, 15));
      end
    end
    plot = 1'b0;
  endtask

  typedef struct {
    int bx, by, bd, mode;
    bit hold;
    int exp_writes;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int wa, wb;
    reset_n   = 1'b0;
    plot      = 1'b0;
    x_pos     = '0;
    y_pos     = '0;
    direction = '0;
    fill_rom(0);

    tbl[0] = '{bx: 10,   by: 20,  bd: 3, mode: 0, hold: 1'b0, exp_writes: 16};
    tbl[1] = '{bx: 100,  by: 50,  bd: 7, mode: 1, hold: 1'b0, exp_writes: 8};
    tbl[2] = '{bx: 638,  by: 478, bd: 2, mode: 0, hold: 1'b0, exp_writes: 4};
    tbl[3] = '{bx: 640,  by: 100, bd: 1, mode: 0, hold: 1'b0, exp_writes: 0};
    tbl[4] = '{bx: 200,  by: 200, bd: 5, mode: 2, hold: 1'b0, exp_writes: 0};
    tbl[5] = '{bx: 0,    by: 479, bd: 9, mode: 0, hold: 1'b0, exp_writes: 4};
    tbl[6] = '{bx: 300,  by: 40,  bd: 3, mode: 4, hold: 1'b1, exp_writes: 16};
    tbl[7] = '{bx: 1020, by: 10,  bd: 0, mode: 0, hold: 1'b0, exp_writes: 0};
    tbl[8] = '{bx: 637,  by: 0,   bd: 4, mode: 0, hold: 1'b0, exp_writes: 12};

    repeat (2) @(negedge clk);
    chk_zero("por");
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      fill_rom(tbl[i].mode);
      run_draw(tbl[i].bx, tbl[i].by, tbl[i].bd, tbl[i].hold, 1'b1, wa, wb);
      chk($sformatf("vec%0d A writes", i), wa, tbl[i].exp_writes);
      chk($sformatf("vec%0d B writes", i), wb, tbl[i].exp_writes);
    end

    // Reset asserted while pixel 7 is being addressed aborts the draw.
    fill_rom(0);
    apply_reset();
    @(negedge clk);
    plot = 1'b1; x_pos = 10'd10; y_pos = 10'd20; direction = 4'd3;
    @(posedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      plot = 1'b0;
      chk($sformatf("abort c%0d A addr", cyc), rom_address_a, 48 + cyc - 1);
      chk($sformatf("abort c%0d B addr", cyc), rom_address_b, 48 + cyc - 1);
    end
    chk("abort A we before reset", we_a, 1);
    reset_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      chk($sformatf("post-abort %0d A we", cyc), we_a | done_a | busy_a, 0);
      chk($sformatf("post-abort %0d B we", cyc), we_b | done_b | busy_b, 0);
    end
    run_draw(10, 20, 3, 1'b0, 1'b0, wa, wb);
    chk("redraw A writes", wa, 16);
    chk("redraw B writes", wb, 16);

    // Randomized placements and ROM contents against the model.
    for (int i = 0; i < 20; i++) begin
      int bx, by;
      fill_rom(3);
      bx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1023) : $urandom_range(620, 645);
      by = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1023) : $urandom_range(460, 485);
      run_draw(bx, by, $urandom_range(0, 15), 1'b0, 1'b1, wa, wb);
      chk($sformatf("rand%0d A writes", i), wa, exp_total);
      chk($sformatf("rand%0d B writes", i), wb, exp_total);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
